key_conditioner: RTL and testbench
==================================

# key_conditioner

Clocked conditioner for the board push-buttons (active-low KEYs) that drive the theta adjustment and other front-panel controls. Synchronises and debounces each raw key and emits clean, single-cycle, active-low "press" strobes with hold-to-repeat, the event format the button-driven controllers consume on their `i_increase` / `i_decrease` style inputs. Also provides a debounced level and a release strobe per key. Sits between the KEY pins and any block that adjusts a setpoint from buttons.

## Interface

Parameters:
- `N_KEYS`, 2: number of independent key channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥ 1.
- `REPEAT_DELAY`, 25000000: cycles from the initial press strobe to the first repeat strobe; 0 disables auto-repeat.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat strobes; must be ≥ 1 when `REPEAT_DELAY` > 0.
- `LOCKOUT`, 1: when 1, only one key may be active at a time.
- `CNT_W`, 32: counter width; must represent the largest of the three cycle parameters.

Ports:
- `i_clock`, input, 1: single system clock, rising edge.
- `i_reset`, input, 1: asynchronous, active-low reset.
- `i_key`, input, N_KEYS: raw keys, active-low (0 = pressed), asynchronous to `i_clock`.
- `o_pressed`, output, N_KEYS: debounced level, active-high.
- `o_press_n`, output, N_KEYS: press/repeat strobe, active-low, exactly one cycle wide.
- `o_release`, output, N_KEYS: release strobe, active-high, one cycle wide.

## Operation

- Per key, a 2-FF synchroniser. Both stages reset to 1 (released).
- Debounce: one counter per key. It increments while the synchronised sample differs from the stable state and clears to 0 whenever they match. When it reaches `DEBOUNCE_CYCLES`, the stable state flips and the counter clears. Any glitch shorter than `DEBOUNCE_CYCLES` cycles changes nothing.
- Per-key FSM states:
  - IDLE: stable released.
  - DELAY: stable pressed; counting toward the first repeat.
  - REPEAT: counting `REPEAT_PERIOD`.
  - BLOCKED: stable pressed but locked out.
- IDLE → DELAY on a stable press edge. Assert `o_press_n`=0 for 1 cycle and `o_pressed`=1. Clear the repeat counter.
- DELAY: when the counter reaches `REPEAT_DELAY`, emit a strobe, clear the counter, and go to REPEAT. With `REPEAT_DELAY`=0, stay in DELAY with no further strobes.
- REPEAT: emit a strobe every `REPEAT_PERIOD` cycles.
- Stable release edge from DELAY or REPEAT → IDLE. `o_release`=1 for 1 cycle, `o_pressed`=0. No strobe is emitted on the release cycle, even if a repeat would fall due.
- Lockout (`LOCKOUT`=1): a stable press edge while another key is in DELAY or REPEAT goes to BLOCKED. BLOCKED emits no strobes, keeps `o_pressed`=0, and gives no `o_release`.
  - BLOCKED → IDLE on that key's stable release.
  - A BLOCKED key does not become active when the owner releases; it must be released and pressed again.
- Simultaneous press edges in the same cycle with `LOCKOUT`=1: the lowest index wins; the others go to BLOCKED.
- With `LOCKOUT`=0, channels are fully independent; simultaneous strobes are allowed.
- Counters never wrap. Each clears on its terminal condition or on a state exit.

## Timing

- Reset values (asynchronous, while `i_reset`=0):
  - `o_pressed`=0, `o_press_n`=all 1, `o_release`=0.
  - Synchroniser stages = 1, all counters 0, all FSMs IDLE.
- All outputs are registered; there is no combinational path from `i_key` to the outputs.
- Press latency: `i_key` falls and stays low, first sampled low at edge 0. `o_press_n` goes low after edge `DEBOUNCE_CYCLES`+3 and stays low for exactly one cycle. `o_pressed` rises on the same edge.
- Release latency is the same, measured to `o_release`.
- Repeat strobes:
  - First repeat: `REPEAT_DELAY` cycles after the initial strobe edge.
  - Subsequent repeats: every `REPEAT_PERIOD` cycles.
- Reset mid-operation: all state is dropped. A key still held after reset deasserts is treated as a new press, with a full debounce and a fresh strobe.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `N_KEYS`=2 unless stated.

- Reset: hold `i_reset`=0 with keys toggling → outputs stay at reset values. Key 0 low from sampling edge 0 after release → `o_press_n[0]`=0 at edge 7 only, `o_pressed[0]`=1 from edge 7.
- Bounce: key 0 low 3 cycles, high 1, low 3, high → no strobe, `o_pressed` stays 0.
- Auto-repeat: hold key 0 for 30 cycles after initial strobe at edge 7 → strobes at edges 7, 17, 20, 23, 26, 29, 32, 35. Release → `o_release[0]` pulse 7 cycles after the release sample; no strobe in that cycle.
- Lockout: press key 0, then key 1 while 0 is held → no key 1 strobe, `o_pressed[1]`=0. Release key 0 while key 1 is still held → still no key 1 strobe. Release and re-press key 1 → strobe.
- Simultaneous press, `LOCKOUT`=1 → only key 0 strobes. With `LOCKOUT`=0 → both strobe on the same edge.
- Reset mid-repeat: assert reset during REPEAT with the key held, then deassert → outputs clear immediately; a fresh strobe comes 7 cycles after reset release.

Source files
------------

// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, debounce, and per-key press/repeat/release
// event FSM with optional single-owner lockout. All outputs are registered.
module key_conditioner #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int LOCKOUT         = 1,
    parameter int CNT_W           = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [N_KEYS-1:0] i_key,
    output logic [N_KEYS-1:0] o_pressed,
    output logic [N_KEYS-1:0] o_press_n,
    output logic [N_KEYS-1:0] o_release
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_DELAY   = 2'b01,
        ST_REPEAT  = 2'b10,
        ST_BLOCKED = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES);
    // Repeat counters start at 0 on the strobe cycle, so the terminal value is one less.
    localparam logic [CNT_W-1:0] RD_LAST  = (REPEAT_DELAY > 0)  ? CNT_W'(REPEAT_DELAY - 1)  : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] RP_LAST  = (REPEAT_PERIOD > 0) ? CNT_W'(REPEAT_PERIOD - 1) : {CNT_W{1'b0}};

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] r_stable;
    logic [CNT_W-1:0]  r_dcnt [N_KEYS];
    state_t            r_state [N_KEYS];
    logic [CNT_W-1:0]  r_rcnt [N_KEYS];
    logic [N_KEYS-1:0] r_pressed;
    logic [N_KEYS-1:0] r_press_n;
    logic [N_KEYS-1:0] r_release;

    state_t            w_state_nxt [N_KEYS];
    logic [CNT_W-1:0]  w_rcnt_nxt [N_KEYS];
    logic [N_KEYS-1:0] w_active;
    logic [N_KEYS-1:0] w_press_edge;
    logic [N_KEYS-1:0] w_lock;
    logic [N_KEYS-1:0] w_pressed_nxt;
    logic [N_KEYS-1:0] w_press_n_nxt;
    logic [N_KEYS-1:0] w_release_nxt;

    // Two-stage synchroniser, idles at released (1).
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= {N_KEYS{1'b1}};
            r_sync2 <= {N_KEYS{1'b1}};
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: stable level flips once the counter has reached its terminal value.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_stable <= {N_KEYS{1'b1}};
            for (int i = 0; i < N_KEYS; i++) r_dcnt[i] <= CNT_ZERO;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (r_dcnt[i] == DB_LAST) begin
                    r_stable[i] <= ~r_stable[i];
                    r_dcnt[i]   <= CNT_ZERO;
                end else if (r_sync2[i] != r_stable[i]) begin
                    r_dcnt[i] <= r_dcnt[i] + CNT_ONE;
                end else begin
                    r_dcnt[i] <= CNT_ZERO;
                end
            end
        end
    end

    // Ownership: a new press is locked out by any active key or by a lower-index simultaneous press.
    always_comb begin
        w_active     = {N_KEYS{1'b0}};
        w_press_edge = {N_KEYS{1'b0}};
        w_lock       = {N_KEYS{1'b0}};
        for (int i = 0; i < N_KEYS; i++) begin
            w_active[i]     = (r_state[i] == ST_DELAY) || (r_state[i] == ST_REPEAT);
            w_press_edge[i] = (r_state[i] == ST_IDLE) && !r_stable[i];
        end
        for (int i = 0; i < N_KEYS; i++) begin
            for (int j = 0; j < N_KEYS; j++) begin
                if ((j != i) && w_active[j]) begin
                    w_lock[i] = 1'b1;
                end else if ((j < i) && w_press_edge[j]) begin
                    w_lock[i] = 1'b1;
                end else begin
                    w_lock[i] = w_lock[i];
                end
            end
            if (LOCKOUT == 0) begin
                w_lock[i] = 1'b0;
            end else begin
                w_lock[i] = w_lock[i];
            end
        end
    end

    // Per-key event FSM: next state, repeat counter and strobe decisions.
    always_comb begin
        w_press_n_nxt = {N_KEYS{1'b1}};
        w_release_nxt = {N_KEYS{1'b0}};
        w_pressed_nxt = {N_KEYS{1'b0}};
        for (int i = 0; i < N_KEYS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_rcnt_nxt[i]  = r_rcnt[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (!r_stable[i]) begin
                        w_rcnt_nxt[i] = CNT_ZERO;
                        if (w_lock[i]) begin
                            w_state_nxt[i] = ST_BLOCKED;
                        end else begin
                            w_state_nxt[i]   = ST_DELAY;
                            w_press_n_nxt[i] = 1'b0;
                        end
                    end else begin
                        w_rcnt_nxt[i] = CNT_ZERO;
                    end
                end
                ST_DELAY: begin
                    if (r_stable[i]) begin
                        w_state_nxt[i]   = ST_IDLE;
                        w_release_nxt[i] = 1'b1;
                        w_rcnt_nxt[i]    = CNT_ZERO;
                    end else if (REPEAT_DELAY == 0) begin
                        w_rcnt_nxt[i] = CNT_ZERO;
                    end else if (r_rcnt[i] == RD_LAST) begin
                        w_state_nxt[i]   = ST_REPEAT;
                        w_press_n_nxt[i] = 1'b0;
                        w_rcnt_nxt[i]    = CNT_ZERO;
                    end else begin
                        w_rcnt_nxt[i] = r_rcnt[i] + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (r_stable[i]) begin
                        w_state_nxt[i]   = ST_IDLE;
                        w_release_nxt[i] = 1'b1;
                        w_rcnt_nxt[i]    = CNT_ZERO;
                    end else if (r_rcnt[i] == RP_LAST) begin
                        w_press_n_nxt[i] = 1'b0;
                        w_rcnt_nxt[i]    = CNT_ZERO;
                    end else begin
                        w_rcnt_nxt[i] = r_rcnt[i] + CNT_ONE;
                    end
                end
                ST_BLOCKED: begin
                    w_rcnt_nxt[i] = CNT_ZERO;
                    if (r_stable[i]) begin
                        w_state_nxt[i] = ST_IDLE;
                    end else begin
                        w_state_nxt[i] = ST_BLOCKED;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                    w_rcnt_nxt[i]  = CNT_ZERO;
                end
            endcase
            w_pressed_nxt[i] = (w_state_nxt[i] == ST_DELAY) || (w_state_nxt[i] == ST_REPEAT);
        end
    end

    // State, repeat counters and registered outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < N_KEYS; i++) begin
                r_state[i] <= ST_IDLE;
                r_rcnt[i]  <= CNT_ZERO;
            end
            r_pressed <= {N_KEYS{1'b0}};
            r_press_n <= {N_KEYS{1'b1}};
            r_release <= {N_KEYS{1'b0}};
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_rcnt[i]  <= w_rcnt_nxt[i];
            end
            r_pressed <= w_pressed_nxt;
            r_press_n <= w_press_n_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign o_pressed = r_pressed;
    assign o_press_n = r_press_n;
    assign o_release = r_release;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: a lockout and a free-running instance share the key inputs and are
// compared every cycle against an event-level model of debounce, strobe schedule and ownership.
module tb_key_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int M_IDLE = 0;
    localparam int M_ACT  = 1;
    localparam int M_BLK  = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] key   = 2'b11;
    logic [1:0] pr_a, pn_a, rl_a;
    logic [1:0] pr_b, pn_b, rl_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state
    int   now;
    logic acc [2];
    int   run [2];
    bit   skip [2];
    int   ev_t [2];
    logic ev_lvl [2];
    int   mode [2][2];
    int   nxt [2][2];
    logic [1:0] exp_pr [2];
    logic [1:0] exp_pn [2];
    logic [1:0] exp_rl [2];

    always #5 clk = ~clk;

    key_conditioner #(.N_KEYS(2), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                      .LOCKOUT(1), .CNT_W(8)) dut_lock (
        .i_clock(clk), .i_reset(rst_n), .i_key(key),
        .o_pressed(pr_a), .o_press_n(pn_a), .o_release(rl_a));

    key_conditioner #(.N_KEYS(2), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                      .LOCKOUT(0), .CNT_W(8)) dut_free (
        .i_clock(clk), .i_reset(rst_n), .i_key(key),
        .o_pressed(pr_b), .o_press_n(pn_b), .o_release(rl_b));

    task automatic model_reset();
        now = -1;
        for (int i = 0; i < 2; i++) begin
            acc[i] = 1'b1; run[i] = 0; skip[i] = 1'b0; ev_t[i] = -100; ev_lvl[i] = 1'b1;
        end
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 2; i++) begin
                mode[v][i] = M_IDLE; nxt[v][i] = -1;
            end
            exp_pr[v] = 2'b00; exp_pn[v] = 2'b11; exp_rl[v] = 2'b00;
        end
    endtask

    // One rising edge: k is the raw key value sampled on it.
    task automatic model_edge(input logic [1:0] k);
        int  bef [2];
        bit  hev [2];
        bit  blk;
        logic [1:0] pn, rl, pr;
        now++;
        // A level is accepted after DB consecutive differing samples; it reaches the outputs
        // four edges after the last of them, and the sample right after acceptance is ignored.
        for (int i = 0; i < 2; i++) begin
            if (skip[i]) begin
                skip[i] = 1'b0;
            end else if (k[i] != acc[i]) begin
                run[i]++;
                if (run[i] == DB) begin
                    acc[i] = k[i]; run[i] = 0; skip[i] = 1'b1;
                    ev_t[i] = now + 4; ev_lvl[i] = k[i];
                end
            end else begin
                run[i] = 0;
            end
        end
        for (int v = 0; v < 2; v++) begin
            pn = 2'b11; rl = 2'b00; pr = 2'b00;
            for (int i = 0; i < 2; i++) begin
                bef[i] = mode[v][i];
                hev[i] = (ev_t[i] == now);
            end
            for (int i = 0; i < 2; i++) begin
                if (bef[i] == M_ACT && !hev[i] && nxt[v][i] == now) begin
                    pn[i] = 1'b0;
                    nxt[v][i] = now + RP;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (hev[i]) begin
                    if (ev_lvl[i]) begin
                        if (bef[i] == M_ACT) rl[i] = 1'b1;
                        mode[v][i] = M_IDLE;
                    end else begin
                        blk = 1'b0;
                        if (v == 0) begin
                            for (int j = 0; j < 2; j++) begin
                                if (j != i && bef[j] == M_ACT) blk = 1'b1;
                                if (j < i && hev[j] && !ev_lvl[j]) blk = 1'b1;
                            end
                        end
                        if (blk) begin
                            mode[v][i] = M_BLK;
                        end else begin
                            mode[v][i] = M_ACT;
                            pn[i] = 1'b0;
                            nxt[v][i] = (RD > 0) ? now + RD : -1;
                        end
                    end
                end
            end
            for (int i = 0; i < 2; i++) pr[i] = (mode[v][i] == M_ACT);
            exp_pr[v] = pr; exp_pn[v] = pn; exp_rl[v] = rl;
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b edge=%0d t=%0t", tag, obs, expv, now, $time);
        end
    endtask

    task automatic compare_all();
        check("lock.o_pressed", pr_a, exp_pr[0]);
        check("lock.o_press_n", pn_a, exp_pn[0]);
        check("lock.o_release", rl_a, exp_rl[0]);
        check("free.o_pressed", pr_b, exp_pr[1]);
        check("free.o_press_n", pn_b, exp_pn[1]);
        check("free.o_release", rl_b, exp_rl[1]);
    endtask

    // Called at a falling edge: drive k, let one rising edge sample it, check at the next fall.
    task automatic tick(input logic [1:0] k);
        key = k;
        @(posedge clk);
        if (rst_n) model_edge(k);
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic [1:0] k, input int n);
        repeat (n) tick(k);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (n) tick(2'($urandom_range(0, 3)));
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 compare_all();
        @(negedge clk);
        // keys toggling under reset
        hold(2'b00, 2); hold(2'b10, 2); hold(2'b01, 2); hold(2'b11, 1);
        rst_n = 1'b1;
        // first press + auto-repeat, then release
        hold(2'b10, 40);
        hold(2'b11, 15);
        // bounce shorter than the debounce window
        hold(2'b10, 3); hold(2'b11, 1); hold(2'b10, 3); hold(2'b11, 12);
        // lockout: key1 pressed while key0 owns, key0 released first, then key1 re-pressed
        hold(2'b10, 12); hold(2'b00, 20); hold(2'b01, 20);
        hold(2'b11, 10); hold(2'b01, 20); hold(2'b11, 15);
        // simultaneous press
        hold(2'b00, 20); hold(2'b11, 15);
        // reset mid-repeat with the key held through it
        hold(2'b10, 25);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        hold(2'b10, 3);
        rst_n = 1'b1;
        hold(2'b10, 20); hold(2'b11, 15);
        // randomized segments: short glitches and long holds, occasional reset
        for (int s = 0; s < 120; s++) begin
            if ($urandom_range(0, 29) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else if ($urandom_range(0, 1) == 0) begin
                hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
            end else begin
                hold(2'($urandom_range(0, 3)), int'($urandom_range(5, 30)));
            end
        end
        hold(2'b11, 15);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
